// File: rtl/trace_capture.sv
// Pre/post-trigger probe capture into a circular buffer, read out oldest-first over valid/ready.
// Define TRACE_TIMESTAMP_EN to prepend the 64-bit emu_time to each record.
module trace_capture #(
  parameter int N_CH      = 8,
  parameter int WIDTH     = 18,
  parameter int DEPTH     = 1024,
  parameter int PRE_DEPTH = 256,
`ifdef TRACE_TIMESTAMP_EN
  localparam int REC_W    = N_CH*WIDTH + 65,
`else
  localparam int REC_W    = N_CH*WIDTH + 1,
`endif
  localparam int TCW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic [N_CH*WIDTH-1:0]   ch_data,
  input  logic                    digital_sel_probe,
  input  logic [63:0]             emu_time,
  input  logic                    emu_dec_cmp,
  input  logic                    arm,
  input  logic [TCW-1:0]          trig_ch,
  input  logic signed [WIDTH-1:0] trig_level,
  input  logic                    trig_falling,
  output logic [2:0]              state,
  output logic [REC_W-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done
);
  localparam int AW     = $clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE_DEPTH;
  localparam logic [AW:0]   ONE       = (AW+1)'(1);
  localparam logic [AW:0]   PRE_LAST  = (AW+1)'(PRE_DEPTH - 1);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(POST_N - 1);
  localparam logic [AW:0]   REC_LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READOUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [REC_W-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             cnt, rd_cnt;
  logic signed [WIDTH-1:0] prev, cur;
  logic [TCW-1:0]          sel;
  logic [REC_W-1:0]        rec;
  logic                    store, hit, fetch, xfer, last_xfer;

`ifdef TRACE_TIMESTAMP_EN
  assign rec = {emu_time, digital_sel_probe, ch_data};
`else
  logic unused_time;
  assign unused_time = ^emu_time;
  assign rec = {digital_sel_probe, ch_data};
`endif

  always_comb begin
    sel   = (int'(trig_ch) < N_CH) ? trig_ch : '0;
    cur   = ch_data[int'(sel)*WIDTH +: WIDTH];
    hit   = trig_falling ? (prev >= trig_level && trig_level > cur)
                         : (prev <  trig_level && trig_level <= cur);
    store = emu_dec_cmp && (state_q == PRE || state_q == WAIT_TRIG || state_q == POST);
    xfer      = rd_valid && rd_ready;
    last_xfer = xfer && (cnt == REC_LAST);
    // Refill the output register whenever it is empty or being consumed.
    fetch = (state_q == READOUT) && (rd_cnt != DEPTH_C) && (!rd_valid || rd_ready);
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arm) state_d = PRE;
      PRE:       if (store && cnt == PRE_LAST) state_d = WAIT_TRIG;
      WAIT_TRIG: if (store && hit) state_d = (POST_N == 1) ? READOUT : POST;
      POST:      if (store && cnt == POST_LAST) state_d = READOUT;
      READOUT:   if (last_xfer) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge emu_clk) begin
    if (store) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      prev     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_xfer;
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (store && (state_q == PRE || state_q == WAIT_TRIG)) prev <= cur;

      case (state_q)
        IDLE:      cnt <= '0;
        PRE:       if (store) cnt <= (cnt == PRE_LAST) ? '0 : cnt + ONE;
        WAIT_TRIG: if (store && hit) cnt <= (POST_N == 1) ? '0 : ONE;
        POST:      if (store) cnt <= (cnt == POST_LAST) ? '0 : cnt + ONE;
        READOUT:   if (xfer) cnt <= cnt + ONE;
        default:   cnt <= '0;
      endcase

      // Outside readout the read pointer shadows the next write slot, i.e. the oldest record.
      if (state_q != READOUT) begin
        rd_ptr <= store ? wr_ptr + PTR_ONE : wr_ptr;
        rd_cnt <= '0;
      end else if (fetch) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + PTR_ONE;
        rd_cnt   <= rd_cnt + ONE;
      end else if (xfer) begin
        rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture against a sample-list reference model.
`timescale 1ns/1ps
module tb_trace_capture;
  localparam int N_CH = 2, WIDTH = 8, DEPTH = 8, PRE_DEPTH = 3;
  localparam int POST_N = DEPTH - PRE_DEPTH;
  localparam int REC_W = N_CH*WIDTH + 1;
  localparam int MAXS = 128;

  logic                    emu_clk = 1'b0;
  logic                    emu_rst = 1'b1;
  logic [N_CH*WIDTH-1:0]   ch_data = '0;
  logic                    digital_sel_probe = 1'b0;
  logic [63:0]             emu_time = '0;
  logic                    emu_dec_cmp = 1'b0;
  logic                    arm = 1'b0;
  logic [0:0]              trig_ch = '0;
  logic signed [WIDTH-1:0] trig_level = '0;
  logic                    trig_falling = 1'b0;
  logic [2:0]              state;
  logic [REC_W-1:0]        rd_data;
  logic                    rd_valid;
  logic                    rd_ready = 1'b0;
  logic                    done;

  trace_capture #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .PRE_DEPTH(PRE_DEPTH)) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .ch_data(ch_data),
    .digital_sel_probe(digital_sel_probe), .emu_time(emu_time),
    .emu_dec_cmp(emu_dec_cmp), .arm(arm), .trig_ch(trig_ch),
    .trig_level(trig_level), .trig_falling(trig_falling), .state(state),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done)
  );

  always #5 emu_clk = ~emu_clk;

  int total = 0;
  int passed = 0;
  logic signed [WIDTH-1:0] s0 [MAXS];
  logic signed [WIDTH-1:0] s1 [MAXS];
  logic                    sp [MAXS];
  int n_samp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Index of the first sample (counted from arm) that fires the trigger, -1 if none.
  function automatic int find_trig(input logic ch, input logic fall, input logic signed [WIDTH-1:0] lvl);
    int p, c, l;
    l = lvl;
    for (int i = PRE_DEPTH; i < n_samp; i++) begin
      p = ch ? s1[i-1] : s0[i-1];
      c = ch ? s1[i]   : s0[i];
      if (!fall && p < l && l <= c) return i;
      if (fall && p >= l && l > c) return i;
    end
    return -1;
  endfunction

  // Expected state after k stored samples, given trigger index t.
  function automatic logic [2:0] mstate(input int k, input int t);
    if (k < PRE_DEPTH) return 3'd1;
    if (t < 0 || k <= t) return 3'd2;
    if (k < t + POST_N) return 3'd3;
    return 3'd4;
  endfunction

  task automatic capture(input string nm, input logic ch, input logic fall,
                         input logic signed [WIDTH-1:0] lvl, input int strobe_pct,
                         input int rdy_mode, input int rst_post, input bit arm_wait);
    int t, k, guard, iter, n_rx, dones, idx;
    bit rearmed, stalled;
    logic [REC_W-1:0] held, exp_rec;
    t = find_trig(ch, fall, lvl);
    trig_ch = ch; trig_falling = fall; trig_level = lvl;
    rd_ready = 1'(($urandom));
    @(negedge emu_clk);
    check({nm, "_idle"}, state, 3'd0);
    arm = 1'b1; emu_dec_cmp = 1'b1; ch_data = 16'($urandom); digital_sel_probe = 1'($urandom);
    k = 0; guard = 0; rearmed = 1'b0;
    forever begin
      @(negedge emu_clk);
      arm = 1'b0;
      check({nm, "_state"}, state, mstate(k, t));
      check({nm, "_vld_cap"}, rd_valid, 1'b0);
      if (mstate(k, t) == 3'd4 || k == n_samp || guard > 2000) break;
      if (rst_post >= 0 && t >= 0 && k == t + rst_post) begin
        #2 emu_rst = 1'b1;
        #1;
        check({nm, "_rst_state"}, state, 3'd0);
        check({nm, "_rst_vld"}, rd_valid, 1'b0);
        check({nm, "_rst_done"}, done, 1'b0);
        check({nm, "_rst_data"}, rd_data, '0);
        @(negedge emu_clk);
        emu_rst = 1'b0; emu_dec_cmp = 1'b0;
        return;
      end
      guard++;
      arm = arm_wait && !rearmed && (mstate(k, t) == 3'd2);
      if (arm) rearmed = 1'b1;
      emu_dec_cmp = ($urandom_range(99) < strobe_pct);
      emu_time = {$urandom, $urandom};
      if (emu_dec_cmp) begin
        ch_data = {s1[k], s0[k]}; digital_sel_probe = sp[k]; k++;
      end else begin
        ch_data = 16'($urandom); digital_sel_probe = 1'($urandom);
      end
    end
    if (guard > 2000) check({nm, "_cap_timeout"}, 64'(guard), 64'd0);
    if (mstate(k, t) != 3'd4) begin
      // No complete capture possible: abandon it and confirm reset returns to idle.
      emu_rst = 1'b1; #1;
      check({nm, "_abandon"}, state, 3'd0);
      @(negedge emu_clk);
      emu_rst = 1'b0; emu_dec_cmp = 1'b0;
      return;
    end
    n_rx = 0; iter = 0; dones = 0; stalled = 1'b0; held = '0;
    while (n_rx < DEPTH && iter < 200) begin
      @(negedge emu_clk);
      iter++;
      emu_dec_cmp = 1'($urandom); ch_data = 16'($urandom);
      if (done) dones++;
      if (stalled) begin
        check({nm, "_stall_vld"}, rd_valid, 1'b1);
        check({nm, "_stall_dat"}, rd_data, held);
      end
      rd_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? iter[0] : 1'($urandom);
      if (rd_valid && rd_ready) begin
        idx = t + POST_N - DEPTH + n_rx;
        exp_rec = {sp[idx], s1[idx], s0[idx]};
        check({nm, "_rd_data"}, rd_data, exp_rec);
        n_rx++;
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
    end
    check({nm, "_rd_count"}, 64'(n_rx), 64'(DEPTH));
    if (rdy_mode == 0) check({nm, "_throughput"}, 64'(iter), 64'(DEPTH));
    @(negedge emu_clk);
    if (done) dones++;
    check({nm, "_end_state"}, state, 3'd0);
    check({nm, "_end_vld"}, rd_valid, 1'b0);
    check({nm, "_end_done"}, done, 1'b1);
    rd_ready = 1'($urandom); emu_dec_cmp = 1'b0;
    @(negedge emu_clk);
    if (done) dones++;
    check({nm, "_done_once"}, 64'(dones), 64'd1);
  endtask

  task automatic fill_ramp0(input int n);
    n_samp = n;
    for (int i = 0; i < n; i++) begin
      s0[i] = 8'(i - 5); s1[i] = 8'($urandom); sp[i] = 1'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_state", state, 3'd0);
    check("reset_vld", rd_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_data", rd_data, '0);
    @(negedge emu_clk);
    emu_rst = 1'b0;

    fill_ramp0(16);
    capture("ramp", 1'b0, 1'b0, 8'sd0, 100, 0, -1, 1'b0);

    n_samp = 103;
    for (int i = 0; i < n_samp; i++) begin
      s0[i] = 8'sd5; s1[i] = 8'($urandom); sp[i] = 1'($urandom);
    end
    capture("const", 1'b0, 1'b0, 8'sd0, 100, 0, -1, 1'b0);

    n_samp = 16;
    for (int i = 0; i < n_samp; i++) begin
      s1[i] = 8'(3 - i); s0[i] = 8'($urandom); sp[i] = 1'($urandom);
    end
    capture("fall", 1'b1, 1'b1, 8'sd0, 100, 0, -1, 1'b0);

    fill_ramp0(16);
    capture("toggle", 1'b0, 1'b0, 8'sd0, 70, 1, -1, 1'b0);

    fill_ramp0(16);
    capture("postrst", 1'b0, 1'b0, 8'sd0, 100, 0, 2, 1'b0);
    capture("rearm", 1'b0, 1'b0, 8'sd0, 80, 0, -1, 1'b0);

    fill_ramp0(16);
    capture("armwait", 1'b0, 1'b0, 8'sd0, 60, 0, -1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      n_samp = 60;
      for (int i = 0; i < n_samp; i++) begin
        s0[i] = 8'(int'($urandom_range(40)) - 20);
        s1[i] = 8'(int'($urandom_range(40)) - 20);
        sp[i] = 1'($urandom);
      end
      capture("rand", 1'($urandom), 1'($urandom), 8'(int'($urandom_range(10)) - 5),
              50 + int'($urandom_range(50)), 2, -1, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
